// File: rtl/cpu_ctl_pkg.sv
// Shared control definitions for the branch sequencer:
// state encoding, branch opcode and ctl strobe bit map.
package cpu_ctl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T1W,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6
  } state_t;

  localparam logic [4:0] BR_OPCODE = 5'b10010;
  localparam int CTL_W = 16;

  localparam int PC_OUT   = 0;
  localparam int MAR_IN   = 1;
  localparam int INC_PC   = 2;
  localparam int Z_IN     = 3;
  localparam int ZLOW_OUT = 4;
  localparam int PC_IN    = 5;
  localparam int MEM_READ = 6;
  localparam int MDR_IN   = 7;
  localparam int MDR_OUT  = 8;
  localparam int IR_IN    = 9;
  localparam int GRA      = 10;
  localparam int R_OUT    = 11;
  localparam int CON_IN   = 12;
  localparam int Y_IN     = 13;
  localparam int C_OUT    = 14;
  localparam int ALU_ADD  = 15;

  function automatic logic is_branch(input logic [31:0] ir);
    return ir[31:27] == BR_OPCODE;
  endfunction

endpackage

// File: rtl/branch_ctl_decode.sv
// Moore output decode: registered state (and CON for T6)
// to the ctl strobe vector.
module branch_ctl_decode
  import cpu_ctl_pkg::*;
(
  input  state_t           i_state,
  input  logic             i_con_q,
  output logic [CTL_W-1:0] o_ctl
);

  always_comb begin
    o_ctl = '0;
    unique case (i_state)
      S_T0: begin
        o_ctl[PC_OUT] = 1'b1;
        o_ctl[MAR_IN] = 1'b1;
        o_ctl[INC_PC] = 1'b1;
        o_ctl[Z_IN]   = 1'b1;
      end
      S_T1: begin
        o_ctl[ZLOW_OUT] = 1'b1;
        o_ctl[PC_IN]    = 1'b1;
        o_ctl[MEM_READ] = 1'b1;
        o_ctl[MDR_IN]   = 1'b1;
      end
      S_T1W: begin
        o_ctl[MEM_READ] = 1'b1;
        o_ctl[MDR_IN]   = 1'b1;
      end
      S_T2: begin
        o_ctl[MDR_OUT] = 1'b1;
        o_ctl[IR_IN]   = 1'b1;
      end
      S_T3: begin
        o_ctl[GRA]    = 1'b1;
        o_ctl[R_OUT]  = 1'b1;
        o_ctl[CON_IN] = 1'b1;
      end
      S_T4: begin
        o_ctl[PC_OUT] = 1'b1;
        o_ctl[Y_IN]   = 1'b1;
      end
      S_T5: begin
        o_ctl[C_OUT]   = 1'b1;
        o_ctl[ALU_ADD] = 1'b1;
        o_ctl[Z_IN]    = 1'b1;
      end
      S_T6: begin
        o_ctl[ZLOW_OUT] = 1'b1;
        o_ctl[PC_IN]    = i_con_q;
      end
      default: o_ctl = '0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch instruction sequencer FSM (fetch + conditional PC update).
// Optional taken/not-taken counters under BRANCH_SEQ_STATS_EN.
module branch_sequencer
  import cpu_ctl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir_q,
  input  logic        con_q,
  input  logic        mem_ready,
  output logic [15:0] ctl,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        illegal,
  output logic [15:0] taken_cnt,
  output logic [15:0] not_taken_cnt
);

  state_t r_state;
  state_t w_next;
  logic   r_taken;
  logic   r_illegal;
  logic   w_legal;
  logic   w_unused;

  assign w_legal  = is_branch(ir_q);
  assign w_unused = ^ir_q[26:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= (r_state == S_T2) && !w_legal;
      if (r_state == S_T6) r_taken <= con_q;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:       if (start) w_next = S_T0;
      S_T0:         w_next = S_T1;
      S_T1, S_T1W:  w_next = mem_ready ? S_T2 : S_T1W;
      S_T2:         w_next = w_legal ? S_T3 : S_IDLE;
      S_T3:         w_next = S_T4;
      S_T4:         w_next = S_T5;
      S_T5:         w_next = S_T6;
      S_T6:         w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  branch_ctl_decode u_decode (
    .i_state (r_state),
    .i_con_q (con_q),
    .o_ctl   (ctl)
  );

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_T6);
  assign taken   = r_taken;
  assign illegal = r_illegal;

`ifdef BRANCH_SEQ_STATS_EN
  logic [15:0] r_tcnt;
  logic [15:0] r_ncnt;

  // counters stick at all-ones rather than wrapping
  always_ff @(posedge clock) begin
    if (clear) begin
      r_tcnt <= '0;
      r_ncnt <= '0;
    end else if (r_state == S_T6) begin
      if (con_q) begin
        if (r_tcnt != 16'hFFFF) r_tcnt <= r_tcnt + 16'd1;
      end else begin
        if (r_ncnt != 16'hFFFF) r_ncnt <= r_ncnt + 16'd1;
      end
    end
  end

  assign taken_cnt     = r_tcnt;
  assign not_taken_cnt = r_ncnt;
`else
  assign taken_cnt     = '0;
  assign not_taken_cnt = '0;
`endif

endmodule
